// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and receive paths.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StStart,
      StSend,
      StWaitAck,
      StWaitIdle
   } ps2_state_e;

   localparam int unsigned PS2_DATA_BITS = 8;
   localparam int unsigned PS2_STOP_IDX  = 9;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] DEV_ACK      = 8'hFA;

   // PS/2 frames carry odd parity over the eight data bits.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a clock falling-edge strobe.
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic fall_o
);

   logic [1:0] clk_sync_q;
   logic [1:0] data_sync_q;
   logic       clk_prev_q;

   // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[1];
      end
   end

   assign clk_sync_o  = clk_sync_q[1];
   assign data_sync_o = data_sync_q[1];
   assign fall_o      = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8N1+odd-parity frame, ACK check.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       ack_err_o,
   output logic       timeout_err_o
);

   localparam logic [CNT_W-1:0] InhibitLast = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

   logic clk_sync;
   logic data_sync;
   logic fall;

   ps2_sync_edge u_sync (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .clk_sync_o  (clk_sync),
      .data_sync_o (data_sync),
      .fall_o      (fall)
   );

   ps2_state_e       state_q;
   logic [7:0]       shreg_q;
   logic             parity_q;
   logic [3:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             clk_oe_q;
   logic             data_oe_q;
   logic             tx_ready_q;
   logic             done_q;
   logic             ack_err_q;
   logic             timeout_err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         parity_q      <= 1'b0;
         idx_q         <= '0;
         cnt_q         <= '0;
         clk_oe_q      <= 1'b0;
         data_oe_q     <= 1'b0;
         tx_ready_q    <= 1'b1;
         done_q        <= 1'b0;
         ack_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         ack_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               clk_oe_q  <= 1'b0;
               data_oe_q <= 1'b0;
               // tx_ready stays low for the pulse cycle right after a frame ends.
               if (tx_valid_i && tx_ready_q) begin
                  shreg_q    <= tx_data_i;
                  parity_q   <= odd_parity(tx_data_i);
                  cnt_q      <= '0;
                  clk_oe_q   <= 1'b1;
                  tx_ready_q <= 1'b0;
                  state_q    <= StInhibit;
               end else begin
                  tx_ready_q <= 1'b1;
               end
            end
            StInhibit: begin
               if (cnt_q == InhibitLast) begin
                  data_oe_q <= 1'b1;
                  state_q   <= StStart;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StStart: begin
               clk_oe_q <= 1'b0;
               cnt_q    <= '0;
               idx_q    <= '0;
               state_q  <= StSend;
            end
            StSend, StWaitAck: begin
               // Timeout takes priority over a coincident clock fall.
               if (cnt_q == TimeoutLast) begin
                  clk_oe_q      <= 1'b0;
                  data_oe_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (fall) begin
                     if (state_q == StSend) begin
                        if (idx_q < 4'(PS2_DATA_BITS)) begin
                           data_oe_q <= ~shreg_q[idx_q[2:0]];
                        end else if (idx_q == 4'(PS2_STOP_IDX)) begin
                           data_oe_q <= 1'b0;
                           state_q   <= StWaitAck;
                        end else begin
                           data_oe_q <= ~parity_q;
                        end
                        idx_q <= idx_q + 4'd1;
                     end else if (data_sync) begin
                        ack_err_q <= 1'b1;
                        state_q   <= StIdle;
                     end else begin
                        state_q <= StWaitIdle;
                     end
                  end
               end
            end
            StWaitIdle: begin
               if (clk_sync && data_sync) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign tx_ready_o    = tx_ready_q;
   assign busy_o        = (state_q != StIdle);
   assign ps2_clk_oe_o  = clk_oe_q;
   assign ps2_data_oe_o = data_oe_q;
   assign done_o        = done_q;
   assign ack_err_o     = ack_err_q;
   assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INHIBIT = 50;
   localparam int unsigned TIMEOUT = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       tx_ready, clk_oe, data_oe, busy, done, ack_err, to_err;
   logic       clk_line, data_line;

   assign clk_line  = dev_clk & ~clk_oe;
   assign data_line = dev_data & ~data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (20)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .tx_data_i     (tx_data),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (tx_ready),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_data_oe_o (data_oe),
      .busy_o        (busy),
      .done_o        (done),
      .ack_err_o     (ack_err),
      .timeout_err_o (to_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Free-running monitors: cycle stamps and pulse counters.
   int cyc = 0;
   int n_done = 0, n_ack = 0, n_to = 0, n_multi = 0;
   int last_done_cyc = 0, last_to_cyc = 0, last_exit_cyc = 0;
   int n_acc = 0, last_acc_cyc = 0;
   logic prev_clk_oe = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_valid && tx_ready) begin
         n_acc        <= n_acc + 1;
         last_acc_cyc <= cyc;
      end
   end

   always @(negedge clk) begin
      if (done) begin
         n_done        <= n_done + 1;
         last_done_cyc <= cyc;
      end
      if (ack_err) n_ack <= n_ack + 1;
      if (to_err) begin
         n_to        <= n_to + 1;
         last_to_cyc <= cyc;
      end
      if (int'(done) + int'(ack_err) + int'(to_err) > 1) n_multi <= n_multi + 1;
      if (prev_clk_oe && !clk_oe) last_exit_cyc <= cyc;
      prev_clk_oe <= clk_oe;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference frame: data LSB first, odd parity from a ones count, stop bit high.
   function automatic logic [9:0] exp_bits(input logic [7:0] d);
      logic [9:0] r;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         r[i] = d[i];
         ones += int'(d[i]);
      end
      r[8] = (ones % 2 == 0);
      r[9] = 1'b1;
      return r;
   endfunction

   task automatic request(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      #1;
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // Waits for request-to-send (clock released, data low), measuring the inhibit shape.
   task automatic wait_rts(output int hi, output int ov, output logic ok);
      hi = 0;
      ov = 0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (clk_oe) hi++;
         if (clk_oe && data_oe) ov++;
         if (!clk_oe && data_oe) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic dev_cycle(input int half, input logic dbefore, output logic s);
      dev_data = dbefore;
      tick(half);
      dev_clk = 1'b0;
      tick(half);
      dev_clk = 1'b1;
      s = data_line;
   endtask

   task automatic dev_frame(input logic ack, input int half, input int nfalls,
                            output logic [9:0] bits);
      logic s;
      bits = '0;
      for (int k = 1; k <= nfalls; k++) begin
         dev_cycle(half, (k == 11) ? ack : 1'b1, s);
         if (k <= 10) bits[k-1] = s;
      end
      dev_data = 1'b1;
   endtask

   task automatic wait_outcome(input int base, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (n_done + n_ack + n_to != base) break;
      end
      tick(5);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       ack;
      int         half;
      logic       exp_par;
      int         exp_done;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int hi, ov, bd, ba, bt, bm, base, acc_base, done1, acc2;
      logic ok;
      logic [9:0] bits, bits2;
      logic [7:0] d;
      logic a;

      vecs[0] = '{CMD_SET_LEDS, 1'b0, 20, 1'b1, 1};
      vecs[1] = '{8'h00,        1'b0, 12, 1'b1, 1};
      vecs[2] = '{8'h01,        1'b0, 12, 1'b0, 1};
      vecs[3] = '{CMD_ENABLE,   1'b1, 15, 1'b0, 0};
      vecs[4] = '{CMD_RESET,    1'b0, 10, 1'b1, 1};
      vecs[5] = '{DEV_ACK,      1'b0, 25, 1'b1, 1};

      tick(3);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_oe", {clk_oe, data_oe}, 0);
      chk("rst_pulses", {busy, done, ack_err, to_err}, 0);
      rst = 1'b0;
      tick(3);
      chk("idle_tx_ready", tx_ready, 1);

      for (int v = 0; v < 6; v++) begin
         bd = n_done; ba = n_ack; bt = n_to; bm = n_multi;
         request(vecs[v].data);
         wait_rts(hi, ov, ok);
         chk("rts_seen", ok, 1);
         chk("inhibit_len", hi, INHIBIT + 1);
         chk("start_overlap", ov, 1);
         dev_frame(vecs[v].ack, vecs[v].half, 11, bits);
         chk("frame_bits", bits, exp_bits(vecs[v].data));
         chk("parity_bit", bits[8], vecs[v].exp_par);
         wait_outcome(bd + ba + bt, 300);
         chk("done_count", n_done - bd, vecs[v].exp_done);
         chk("ack_err_count", n_ack - ba, 1 - vecs[v].exp_done);
         chk("timeout_count", n_to - bt, 0);
         chk("exclusive", n_multi - bm, 0);
         chk("end_oe", {clk_oe, data_oe}, 0);
         chk("end_ready", {tx_ready, busy}, 2'b10);
      end

      // Device stops clocking after four falls.
      bd = n_done; ba = n_ack; bt = n_to;
      request(8'hA5);
      wait_rts(hi, ov, ok);
      chk("to_rts_seen", ok, 1);
      dev_frame(1'b0, 12, 4, bits);
      wait_outcome(bd + ba + bt, TIMEOUT + 500);
      chk("to_count", n_to - bt, 1);
      chk("to_no_other", (n_done - bd) + (n_ack - ba), 0);
      chk("to_latency", last_to_cyc - last_exit_cyc, TIMEOUT);
      chk("to_oe", {clk_oe, data_oe}, 0);
      chk("to_ready", tx_ready, 1);

      // Reset during inhibit releases the clock line without waiting for an edge.
      base = n_done + n_ack + n_to;
      request(8'h3C);
      tick(10);
      @(negedge clk);
      chk("inh_clk_oe", clk_oe, 1);
      #1 rst = 1'b1;
      #1 chk("inh_rst_async", clk_oe, 0);
      tick(2);
      rst = 1'b0;
      tick(2);
      chk("inh_rst_ready", {tx_ready, busy}, 2'b10);

      // Reset during SEND with bit 4 (a zero) on the line.
      request(8'h00);
      wait_rts(hi, ov, ok);
      for (int k = 0; k < 5; k++) dev_cycle(12, 1'b1, a);
      tick(3);
      @(negedge clk);
      chk("send_data_oe", {busy, data_oe}, 2'b11);
      #1 rst = 1'b1;
      #1 chk("send_rst_async", {clk_oe, data_oe}, 0);
      tick(2);
      rst = 1'b0;
      tick(2);
      chk("send_rst_ready", {tx_ready, busy}, 2'b10);
      chk("rst_no_pulse", n_done + n_ack + n_to, base);

      // Back-to-back with tx_valid held through both frames.
      bd = n_done;
      acc_base = n_acc;
      @(negedge clk);
      while (!tx_ready) @(negedge clk);
      #1;
      tx_data  = CMD_ENABLE;
      tx_valid = 1'b1;
      wait_rts(hi, ov, ok);
      tx_data = CMD_RESET;
      dev_frame(1'b0, 15, 11, bits);
      wait_rts(hi, ov, ok);
      done1 = last_done_cyc;
      acc2  = last_acc_cyc;
      tx_valid = 1'b0;
      chk("b2b_rts2", ok, 1);
      dev_frame(1'b0, 15, 11, bits2);
      wait_outcome(n_done + n_ack + n_to, 300);
      chk("b2b_bits1", bits, exp_bits(CMD_ENABLE));
      chk("b2b_bits2", bits2, exp_bits(CMD_RESET));
      chk("b2b_accepts", n_acc - acc_base, 2);
      chk("b2b_gap", acc2 - done1, 1);
      chk("b2b_done", n_done - bd, 2);

      // Randomized frames against the reference model.
      for (int r = 0; r < 15; r++) begin
         d  = 8'($urandom_range(0, 255));
         a  = ($urandom_range(0, 3) == 0);
         bd = n_done; ba = n_ack; bt = n_to;
         request(d);
         wait_rts(hi, ov, ok);
         dev_frame(a, int'($urandom_range(8, 30)), 11, bits);
         wait_outcome(bd + ba + bt, 300);
         chk("rnd_bits", bits, exp_bits(d));
         chk("rnd_outcome", {n_done - bd, n_ack - ba, n_to - bt},
             {32'(a ? 0 : 1), 32'(a ? 1 : 0), 32'd0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
